// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the 20-bit CPU fetch controller.
// State encoding, instruction/opcode geometry and the HALT opcode.
package fetch_ctrl_pkg;

  localparam int INS_W_DFLT = 20;
  localparam int OPC_W      = 4;

  localparam logic [OPC_W-1:0] HALT_OP_DFLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_VALID  = 3'd3,
    S_HALTED = 3'd4
  } fstate_e;

  // Opcode occupies the top OPC_W bits of an instruction word.
  function automatic logic [OPC_W-1:0] opc_of(
    input logic [INS_W_DFLT-1:0] w
  );
    return w[INS_W_DFLT-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_unit.sv
// Fetch PC and accepted-PC registers for fetch_ctrl.
// Sequential increment and branch-target adder live here.
module fetch_ctrl_pc_unit
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  input  logic              redir_i,
  input  logic              acc_en_i,
  input  logic [ADDR_W-1:0] acc_val_i,
  input  logic [ADDR_W-1:0] off_i,
  output logic [ADDR_W-1:0] fetch_pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] acc_q;
  logic [ADDR_W-1:0] acc_d;
  logic [ADDR_W-1:0] tgt;

  // Target is relative to the last accepted instruction.
  assign tgt = acc_q + off_i;

  // Next fetch PC: a redirect overrides the sequential step.
  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redir_i: pc_d = tgt;
      inc_i:   pc_d = pc_q + ADDR_W'(1);
      default: pc_d = pc_q;
    endcase
  end

  // Accepted PC only moves on a clean (non-flushed) accept.
  always_comb begin
    acc_d = acc_q;
    if (acc_en_i)
      acc_d = acc_val_i;
  end

  // PC state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      acc_q <= RESET_PC;
    end else begin
      pc_q  <= pc_d;
      acc_q <= acc_d;
    end
  end

  assign fetch_pc_o = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: PC, imem reads, decode handshake, HALT.
// Define FETCH_PERF_EN to add fetch_cnt/flush_cnt perf counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INS_W    = INS_W_DFLT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [OPC_W-1:0]  HALT_OP  = HALT_OP_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [INS_W-1:0]  imem_rdata,
  output logic [INS_W-1:0]  ins,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [ADDR_W-1:0] pc,
  input  logic              branch,
  input  logic              zero,
  input  logic [INS_W-1:0]  ext,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  fstate_e state_q;
  fstate_e state_d;

  logic [INS_W-1:0]  ins_q;
  logic [INS_W-1:0]  ins_d;
  logic [ADDR_W-1:0] ipc_q;
  logic [ADDR_W-1:0] ipc_d;
  logic [ADDR_W-1:0] fetch_pc;

  logic taken;
  logic live;
  logic flush;
  logic accept;
  logic cap;
  logic is_halt;
  logic ext_unused;

  assign taken = branch & zero;

  // Redirects only apply while a fetch is in progress.
  assign live  = (state_q == S_REQ) |
                 (state_q == S_WAIT) |
                 (state_q == S_VALID);
  assign flush = taken & live;

  // A flushed accept is not an accept.
  assign accept = (state_q == S_VALID) & ins_ready & ~flush;
  assign cap    = (state_q == S_WAIT) & ~flush;

  assign is_halt = ins_q[INS_W-1 -: OPC_W] == HALT_OP;

  assign ext_unused = ^ext[INS_W-1:ADDR_W];

  fetch_ctrl_pc_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (cap),
    .redir_i    (flush),
    .acc_en_i   (accept),
    .acc_val_i  (ipc_q),
    .off_i      (ext[ADDR_W-1:0]),
    .fetch_pc_o (fetch_pc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // FSM next state; a live redirect always restarts at REQ.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_REQ;
      S_REQ:    state_d = S_WAIT;
      S_WAIT:   state_d = S_VALID;
      S_VALID:
        if (accept)
          state_d = is_halt ? S_HALTED : S_REQ;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
    if (flush)
      state_d = S_REQ;
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    imem_rd   = 1'b0;
    ins_valid = 1'b0;
    halted    = 1'b0;
    unique case (1'b1)
      state_q == S_REQ:    imem_rd   = 1'b1;
      state_q == S_VALID:  ins_valid = 1'b1;
      state_q == S_HALTED: halted    = 1'b1;
      default: ;
    endcase
  end

  // Instruction/PC holding: load on a clean WAIT, else hold.
  always_comb begin
    ins_d = ins_q;
    ipc_d = ipc_q;
    if (cap) begin
      ins_d = imem_rdata;
      ipc_d = fetch_pc;
    end
  end

  // Instruction/PC holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_q <= '0;
      ipc_q <= RESET_PC;
    end else begin
      ins_q <= ins_d;
      ipc_q <= ipc_d;
    end
  end

  assign imem_addr = fetch_pc;
  assign ins       = ins_q;
  assign pc        = ipc_q;

`ifdef FETCH_PERF_EN
  logic [15:0] fcnt_q;
  logic [15:0] fcnt_d;
  logic [15:0] xcnt_q;
  logic [15:0] xcnt_d;

  // Saturating counters of accepts and live redirects.
  always_comb begin
    fcnt_d = fcnt_q;
    xcnt_d = xcnt_q;
    if (accept && fcnt_q != 16'hFFFF)
      fcnt_d = fcnt_q + 16'd1;
    if (flush && xcnt_q != 16'hFFFF)
      xcnt_d = xcnt_q + 16'd1;
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      xcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      xcnt_q <= xcnt_d;
    end
  end

  assign fetch_cnt = fcnt_q;
  assign flush_cnt = xcnt_q;
`endif

endmodule
